// File: rtl/bcd_pkg.sv
// Shared types and helpers for the decimal keypad to BCD accumulator.
// The encoder and the multi-key detector are pure functions of one key sample.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned KEY_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } key_state_t;

    function automatic logic multi_hot(input logic [KEY_W-1:0] sample);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (sample[i]) begin
                ones = ones + 1;
            end
        end
        return (ones > 1);
    endfunction

    // Highest set index wins. A rejected multi-key sample in single-key mode
    // still reports that index, so last_digit_o shows what was seen.
    function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [KEY_W-1:0] sample,
                                                         input logic             multi_mode);
        logic [BCD_W-1:0] hi;
        hi = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (sample[i]) begin
                hi = BCD_W'(i);
            end
        end
        return (multi_mode || !multi_hot(sample)) ? hi : hi;
    endfunction

endpackage

// File: rtl/bcd_key_debounce.sv
// Press/release debouncer for the 10-line keypad.
// commit_o is combinational so the commit lands on the edge that sees the last stable sample.
import bcd_pkg::*;

module bcd_key_debounce #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_i,
    output logic             commit_o,
    output logic [KEY_W-1:0] commit_key_o
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    key_state_t       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] sample_q, sample_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sample_d     = sample_q;
        commit_o     = 1'b0;
        // At any commit key_i equals the stored sample, so it is the committed value.
        commit_key_o = key_i;

        case (state_q)
            IDLE: begin
                if (key_i != '0) begin
                    sample_d = key_i;
                    cnt_d    = 8'd1;
                    if (STABLE == 8'd1) begin
                        commit_o = 1'b1;
                        state_d  = HELD;
                    end else begin
                        state_d  = PRESS;
                    end
                end
            end
            PRESS: begin
                if (key_i == '0) begin
                    state_d = IDLE;
                end else if (key_i == sample_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STABLE) begin
                        commit_o = 1'b1;
                        state_d  = HELD;
                    end
                end else begin
                    sample_d = key_i;
                    cnt_d    = 8'd1;
                end
            end
            HELD: begin
                if (key_i == '0) begin
                    cnt_d   = 8'd1;
                    state_d = (STABLE == 8'd1) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (key_i == '0) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STABLE) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bcd_key_accumulator.sv
// Debounced decimal keypad to NUM_DIGITS-digit BCD word, newest digit in [3:0],
// presented on a valid/ready handshake.
import bcd_pkg::*;

module bcd_key_accumulator #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter bit          MULTI_MODE    = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [KEY_W-1:0]                  key_i,
    input  logic                              clear_i,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [BCD_W*NUM_DIGITS-1:0]       bcd_o,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count_o,
    output logic                              digit_stb_o,
    output logic [BCD_W-1:0]                  last_digit_o,
    output logic                              err_o,
    output logic                              ovf_o
);

    localparam int unsigned W  = BCD_W * NUM_DIGITS;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

    logic             commit;
    logic [KEY_W-1:0] commit_key;

    bcd_key_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_i        (key_i),
        .commit_o     (commit),
        .commit_key_o (commit_key)
    );

    logic [W-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]      count_q, count_d;
    logic               valid_q, valid_d;
    logic [BCD_W-1:0]   last_q, last_d;
    logic               stb_q, stb_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   digit;
    logic [W-1:0]       digit_ext;
    logic               reject;
    logic               transfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            last_q  <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            count_q <= count_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        digit        = onehot10_to_bcd(commit_key, MULTI_MODE);
        digit_ext    = '0;
        digit_ext[BCD_W-1:0] = digit;
        reject       = !MULTI_MODE && multi_hot(commit_key);
        transfer     = valid_q && out_ready;

        bcd_d   = bcd_q;
        count_d = count_q;
        last_d  = last_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        ovf_d   = 1'b0;

        if (clear_i) begin
            bcd_d   = '0;
            count_d = '0;
        end else begin
            // Emptying first lets a same-edge commit become digit 1 of the next word.
            if (transfer) begin
                bcd_d   = '0;
                count_d = '0;
            end
            if (commit) begin
                last_d = digit;
                if (reject) begin
                    err_d = 1'b1;
                end else if (count_d == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    bcd_d   = (bcd_d << BCD_W) | digit_ext;
                    count_d = count_d + CW'(1);
                    stb_d   = 1'b1;
                end
            end
        end

        valid_d = (count_d == FULL);
    end

    assign bcd_o         = bcd_q;
    assign digit_count_o = count_q;
    assign out_valid     = valid_q;
    assign last_digit_o  = last_q;
    assign digit_stb_o   = stb_q;
    assign err_o         = err_q;
    assign ovf_o         = ovf_q;

endmodule
